// File: rtl/al4s3b_fpga_wb_sequencer_pkg.sv
// Shared types and constants for the Wishbone slave sequencer.
// Aperture geometry, default read word and the FSM state encoding.
package al4s3b_fpga_wb_sequencer_pkg;

  localparam int unsigned WB_APERWIDTH = 17;
  localparam int unsigned WB_APERSIZE  = 10;
  localparam int unsigned NUM_SLV      = 4;
  localparam int unsigned SLV_IDX_W    = $clog2(NUM_SLV);

  localparam logic [31:0] WB_DEFAULT_READ_VALUE = 32'hBADFABAC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts ACTIVE cycles of one slave access.
// Flags expiry on the cycle whose increment reaches LIMIT.
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/al4s3b_fpga_wb_sequencer.sv
// Routes Wishbone requests to one of four module apertures,
// with timeout abort and a sticky error log.
module al4s3b_fpga_wb_sequencer
  import al4s3b_fpga_wb_sequencer_pkg::*;
#(
  parameter int unsigned APERWIDTH = WB_APERWIDTH,
  parameter int unsigned APERSIZE  = WB_APERSIZE,
  parameter logic [APERWIDTH-1:0] SLV0_BASE = 17'h04000,
  parameter logic [APERWIDTH-1:0] SLV1_BASE = 17'h05000,
  parameter logic [APERWIDTH-1:0] SLV2_BASE = 17'h06000,
  parameter logic [APERWIDTH-1:0] SLV3_BASE = 17'h07000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] DEFAULT_READ_VALUE = WB_DEFAULT_READ_VALUE
) (
  input  logic                    WBs_CLK_i,
  input  logic                    WBs_RST_i,
  input  logic [APERWIDTH-1:0]    WBs_ADR_i,
  input  logic                    WBs_CYC_i,
  input  logic                    WBs_STB_i,
  input  logic                    WBs_WE_i,
  output logic [31:0]             WBs_DAT_o,
  output logic                    WBs_ACK_o,
  output logic [NUM_SLV-1:0]      SLV_CYC_o,
  input  logic [NUM_SLV-1:0]      SLV_ACK_i,
  input  logic [32*NUM_SLV-1:0]   SLV_DAT_i,
  input  logic                    ERR_CLR_i,
  output logic                    ERR_FLAG_o,
  output logic [APERWIDTH-1:0]    ERR_ADR_o,
  output logic [7:0]              ERR_CNT_o
);

  localparam logic [APERWIDTH-1:0] BASES [NUM_SLV] =
    '{SLV0_BASE, SLV1_BASE, SLV2_BASE, SLV3_BASE};

  state_t state;
  state_t state_nxt;

  logic [SLV_IDX_W-1:0] sel;
  logic [SLV_IDX_W-1:0] hit_idx;
  logic                 hit;
  logic                 req;
  logic [APERWIDTH-1:0] req_adr;
  logic [APERWIDTH-1:0] err_adr_nxt;
  logic [31:0]          slot_dat [NUM_SLV];
  logic [31:0]          dat_nxt;
  logic [NUM_SLV-1:0]   onehot;
  logic                 slv_ack;
  logic                 dat_load;
  logic                 err_log;
  logic                 cnt_clr;
  logic                 expired;
  logic                 unused_we;

  assign unused_we = WBs_WE_i;
  assign req       = WBs_CYC_i & WBs_STB_i;

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if (WBs_ADR_i[APERWIDTH-1:APERSIZE] ==
          BASES[k][APERWIDTH-1:APERSIZE]) begin
        hit     = 1'b1;
        hit_idx = k[SLV_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SLV; k++) begin
      slot_dat[k] = SLV_DAT_i[32*k +: 32];
    end
  end

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

  assign slv_ack   = SLV_ACK_i[sel];
  assign SLV_CYC_o = (state == ST_ACTIVE) ? onehot : '0;
  assign WBs_ACK_o = (state == ST_RESP);

  always_comb begin
    state_nxt   = state;
    dat_load    = 1'b0;
    dat_nxt     = DEFAULT_READ_VALUE;
    err_log     = 1'b0;
    err_adr_nxt = req_adr;
    cnt_clr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            state_nxt = ST_ACTIVE;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt   = ST_RESP;
            dat_load    = 1'b1;
            err_log     = 1'b1;
            err_adr_nxt = WBs_ADR_i;
          end
        end
      end
      ST_ACTIVE: begin
        // Abandon beats ack; ack beats timeout.
        if (!WBs_CYC_i) begin
          state_nxt = ST_IDLE;
        end else if (slv_ack) begin
          state_nxt = ST_RESP;
          dat_load  = 1'b1;
          dat_nxt   = slot_dat[sel];
        end else if (expired) begin
          state_nxt = ST_RESP;
          dat_load  = 1'b1;
          err_log   = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (WBs_CLK_i),
    .rst     (WBs_RST_i),
    .clear   (cnt_clr),
    .enable  (state == ST_ACTIVE),
    .expired (expired)
  );

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state      <= ST_IDLE;
      sel        <= '0;
      req_adr    <= '0;
      WBs_DAT_o  <= '0;
      ERR_FLAG_o <= 1'b0;
      ERR_ADR_o  <= '0;
      ERR_CNT_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        sel     <= hit_idx;
        req_adr <= WBs_ADR_i;
      end
      if (dat_load) begin
        WBs_DAT_o <= dat_nxt;
      end
      // A clear coinciding with a new error restarts the count at one.
      if (err_log) begin
        ERR_FLAG_o <= 1'b1;
        ERR_ADR_o  <= err_adr_nxt;
        if (ERR_CLR_i) begin
          ERR_CNT_o <= 8'd1;
        end else if (ERR_CNT_o != 8'hFF) begin
          ERR_CNT_o <= ERR_CNT_o + 8'd1;
        end
      end else if (ERR_CLR_i) begin
        ERR_FLAG_o <= 1'b0;
        ERR_CNT_o  <= '0;
      end
    end
  end

endmodule
